// File: rtl/lockstep_result_checker.sv
// lockstep_result_checker: golden-vs-faulty result comparator.
// Each result stream is re-aligned through its own small FIFO. Head pairs are popped
// together, compared lane by lane under a mask, and counted. The first failing pair
// is captured for later dump.
module lockstep_result_checker #(
  parameter int LANES = 2,
  parameter int W     = 16,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [CNT_W-1:0]   total_samples,
  input  logic               stop_on_fail,
  input  logic [LANES-1:0]   lane_mask,
  input  logic               gm_valid,
  input  logic [LANES*W-1:0] gm_data,
  output logic               gm_ready,
  input  logic               fm_valid,
  input  logic [LANES*W-1:0] fm_data,
  output logic               fm_ready,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   mismatch_count,
  output logic [CNT_W-1:0]   first_idx,
  output logic [LANES-1:0]   first_lanes,
  output logic [LANES*W-1:0] first_gm,
  output logic [LANES*W-1:0] first_fm
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = LANES * W;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;

  logic [DW-1:0]    gm_mem [DEPTH];
  logic [DW-1:0]    fm_mem [DEPTH];
  logic [AW-1:0]    gm_wp, gm_rp, fm_wp, fm_rp;
  logic [AW:0]      gm_cnt, fm_cnt;

  logic [CNT_W-1:0] total_q;
  logic             stop_q;
  logic [LANES-1:0] mask_q;

  logic             start_ok;
  logic             gm_push, fm_push, pop;
  logic [DW-1:0]    gm_head, fm_head;
  logic [LANES-1:0] lane_miss;
  logic             pair_fail;
  logic [CNT_W-1:0] next_sample;
  logic             end_run;

  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign fail     = (mismatch_count != '0);
  assign start_ok = start && (state != S_RUN);

  // No bypass: a full FIFO refuses data even if its head pops this cycle.
  assign gm_ready = (state == S_RUN) && (gm_cnt != FULL_CNT);
  assign fm_ready = (state == S_RUN) && (fm_cnt != FULL_CNT);
  assign gm_push  = gm_valid && gm_ready;
  assign fm_push  = fm_valid && fm_ready;
  assign pop      = (state == S_RUN) && (gm_cnt != '0) && (fm_cnt != '0);

  assign gm_head     = gm_mem[gm_rp];
  assign fm_head     = fm_mem[fm_rp];
  assign pair_fail   = |lane_miss;
  assign next_sample = sample_count + CNT_W'(1);
  assign end_run     = pop && ((next_sample == total_q) || (pair_fail && stop_q));

  // Per-lane compare of the two FIFO heads; masked-off lanes never mismatch.
  always_comb begin
    lane_miss = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_miss[k] = mask_q[k] && (gm_head[k*W +: W] != fm_head[k*W +: W]);
    end
  end

  // FIFO storage; contents need no reset since occupancy governs validity.
  always_ff @(posedge clock) begin
    if (gm_push) gm_mem[gm_wp] <= gm_data;
    if (fm_push) fm_mem[fm_wp] <= fm_data;
  end

  // FIFO pointers and occupancy; flushed on an accepted start and on entry to DONE.
  always_ff @(posedge clock) begin
    if (reset || start_ok || end_run) begin
      gm_wp  <= '0;
      gm_rp  <= '0;
      gm_cnt <= '0;
      fm_wp  <= '0;
      fm_rp  <= '0;
      fm_cnt <= '0;
    end else begin
      if (gm_push) gm_wp <= gm_wp + AW'(1);
      if (fm_push) fm_wp <= fm_wp + AW'(1);
      if (pop) begin
        gm_rp <= gm_rp + AW'(1);
        fm_rp <= fm_rp + AW'(1);
      end
      gm_cnt <= gm_cnt + (AW+1)'(gm_push) - (AW+1)'(pop);
      fm_cnt <= fm_cnt + (AW+1)'(fm_push) - (AW+1)'(pop);
    end
  end

  // Run control, statistics and first-failure capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= S_IDLE;
      total_q        <= '0;
      stop_q         <= 1'b0;
      mask_q         <= '0;
      sample_count   <= '0;
      mismatch_count <= '0;
      first_idx      <= '0;
      first_lanes    <= '0;
      first_gm       <= '0;
      first_fm       <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            total_q        <= total_samples;
            stop_q         <= stop_on_fail;
            mask_q         <= lane_mask;
            sample_count   <= '0;
            mismatch_count <= '0;
            first_idx      <= '0;
            first_lanes    <= '0;
            first_gm       <= '0;
            first_fm       <= '0;
            state          <= (total_samples == '0) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          if (pop) begin
            sample_count <= next_sample;
            if (pair_fail) begin
              if (mismatch_count != '1) mismatch_count <= mismatch_count + CNT_W'(1);
              if (mismatch_count == '0) begin
                first_idx   <= sample_count;
                first_lanes <= lane_miss;
                first_gm    <= gm_head;
                first_fm    <= fm_head;
              end
            end
            if (end_run) state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lockstep_result_checker.sv
// Testbench for lockstep_result_checker: random streams checked against a pairwise model.
module tb_lockstep_result_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] total_samples = '0;
  logic        stop_on_fail = 1'b0;
  logic [1:0]  lane_mask = '0;
  logic        gm_valid = 1'b0;
  logic [31:0] gm_data = '0;
  logic        gm_ready;
  logic        fm_valid = 1'b0;
  logic [31:0] fm_data = '0;
  logic        fm_ready;
  logic        busy, done, fail;
  logic [15:0] sample_count, mismatch_count, first_idx;
  logic [1:0]  first_lanes;
  logic [31:0] first_gm, first_fm;

  int checks = 0;
  int failures = 0;

  logic [31:0] gm_vec [16];
  logic [31:0] fm_vec [16];

  int          exp_sc, exp_mc, exp_idx;
  logic [1:0]  exp_lanes;
  logic [31:0] exp_gm, exp_fm;
  int          lag_gm_acc;
  logic        lag_gm_ready;

  lockstep_result_checker #(.LANES(2), .W(16), .DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .start(start), .total_samples(total_samples),
    .stop_on_fail(stop_on_fail), .lane_mask(lane_mask),
    .gm_valid(gm_valid), .gm_data(gm_data), .gm_ready(gm_ready),
    .fm_valid(fm_valid), .fm_data(fm_data), .fm_ready(fm_ready),
    .busy(busy), .done(done), .fail(fail), .sample_count(sample_count),
    .mismatch_count(mismatch_count), .first_idx(first_idx), .first_lanes(first_lanes),
    .first_gm(first_gm), .first_fm(first_fm)
  );

  always #5 clock = ~clock;

  // Reference: walk the sample pairs in order, stopping at total or at the first fail if asked.
  task automatic model(input int total, input logic [1:0] mask, input logic stop);
    exp_sc = 0; exp_mc = 0; exp_idx = 0; exp_lanes = '0; exp_gm = '0; exp_fm = '0;
    for (int i = 0; i < total; i++) begin
      logic [1:0] ml;
      ml = '0;
      for (int k = 0; k < 2; k++)
        if (mask[k] && (gm_vec[i][16*k +: 16] != fm_vec[i][16*k +: 16])) ml[k] = 1'b1;
      exp_sc++;
      if (ml != 2'b00) begin
        if (exp_mc == 0) begin
          exp_idx = i; exp_lanes = ml; exp_gm = gm_vec[i]; exp_fm = fm_vec[i];
        end
        exp_mc++;
        if (stop) break;
      end
    end
  endtask

  task automatic gen_vectors(input int n, input int flip_pct);
    for (int i = 0; i < n; i++) begin
      gm_vec[i] = $urandom;
      fm_vec[i] = gm_vec[i];
      if (int'($urandom_range(99)) < flip_pct) fm_vec[i][15:0]  = fm_vec[i][15:0] ^ 16'(1 + $urandom_range(65534));
      if (int'($urandom_range(99)) < flip_pct) fm_vec[i][31:16] = fm_vec[i][31:16] ^ 16'(1 + $urandom_range(65534));
    end
  endtask

  // Called at a negedge; pulses start for one clock.
  task automatic do_start(input int tot, input logic stop, input logic [1:0] mask);
    total_samples = 16'(tot); stop_on_fail = stop; lane_mask = mask; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Feeds both streams until done (or abort point / cycle budget); handshake judged at negedge.
  task automatic drive_streams(input int n, input int fm_lag, input bit gaps,
                               input int abort_at, output bit timed_out);
    int gi = 0, fi = 0, cyc = 0;
    timed_out = 1'b0;
    while (!done) begin
      if (cyc >= 2000) begin timed_out = 1'b1; break; end
      if (abort_at >= 0 && int'(sample_count) == abort_at) break;
      gm_valid = (gi < n) && (!gaps || $urandom_range(3) != 0);
      gm_data  = (gi < n) ? gm_vec[gi] : '0;
      fm_valid = (fi < n) && (cyc >= fm_lag) && (!gaps || $urandom_range(3) != 0);
      fm_data  = (fi < n) ? fm_vec[fi] : '0;
      if (cyc == fm_lag) begin lag_gm_acc = gi; lag_gm_ready = gm_ready; end
      if (gm_valid && gm_ready) gi++;
      if (fm_valid && fm_ready) fi++;
      @(negedge clock);
      cyc++;
    end
    gm_valid = 1'b0; fm_valid = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (busy !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin failures++;
      $display("FAIL reset_flags: busy=%b done=%b fail=%b required 000", busy, done, fail); end
    checks++; if (gm_ready !== 1'b0 || fm_ready !== 1'b0) begin failures++;
      $display("FAIL reset_ready: gm=%b fm=%b required 00", gm_ready, fm_ready); end
    checks++; if (sample_count !== 16'd0 || mismatch_count !== 16'd0 || first_idx !== 16'd0) begin failures++;
      $display("FAIL reset_counts: sc=%0d mc=%0d idx=%0d required 0", sample_count, mismatch_count, first_idx); end
    checks++; if (first_lanes !== 2'b00 || first_gm !== 32'd0 || first_fm !== 32'd0) begin failures++;
      $display("FAIL reset_first: lanes=%b gm=%h fm=%h required 0", first_lanes, first_gm, first_fm); end
  endtask

  task automatic test_identical();
    bit to;
    gen_vectors(4, 0);
    do_start(4, 1'b0, 2'b11);
    drive_streams(4, 0, 1'b1, -1, to);
    checks++; if (to) begin failures++; $display("FAIL ident_timeout: done=%b required 1", done); end
    checks++; if (sample_count !== 16'd4 || fail !== 1'b0 || busy !== 1'b0) begin failures++;
      $display("FAIL ident_result: sc=%0d fail=%b busy=%b required sc=4 fail=0 busy=0", sample_count, fail, busy); end
    checks++; if (gm_ready !== 1'b0 || fm_ready !== 1'b0) begin failures++;
      $display("FAIL ident_ready_done: gm=%b fm=%b required 00", gm_ready, fm_ready); end
  endtask

  task automatic test_single_mismatch();
    bit to;
    gen_vectors(5, 0);
    gm_vec[2][15:0] = 16'h0014;
    fm_vec[2] = {gm_vec[2][31:16], 16'h0015};
    model(5, 2'b11, 1'b0);
    do_start(5, 1'b0, 2'b11);
    drive_streams(5, 0, 1'b1, -1, to);
    checks++; if (to) begin failures++; $display("FAIL mism_timeout: done=%b required 1", done); end
    checks++; if (int'(mismatch_count) !== exp_mc || exp_mc != 1) begin failures++;
      $display("FAIL mism_count: got %0d required 1", mismatch_count); end
    checks++; if (first_idx !== 16'd2 || first_lanes !== 2'b01 || int'(sample_count) !== exp_sc) begin failures++;
      $display("FAIL mism_first: idx=%0d lanes=%b sc=%0d required idx=2 lanes=01 sc=5", first_idx, first_lanes, sample_count); end
    checks++; if (first_gm[15:0] !== 16'h0014 || first_fm[15:0] !== 16'h0015) begin failures++;
      $display("FAIL mism_lane0: gm=%h fm=%h required 0014/0015", first_gm[15:0], first_fm[15:0]); end
    checks++; if (first_gm !== exp_gm || first_fm !== exp_fm || fail !== 1'b1) begin failures++;
      $display("FAIL mism_data: gm=%h fm=%h fail=%b required %h %h 1", first_gm, first_fm, fail, exp_gm, exp_fm); end
  endtask

  task automatic test_mask_and_stop();
    bit to;
    do_start(5, 1'b0, 2'b10);
    drive_streams(5, 0, 1'b1, -1, to);
    checks++; if (to || fail !== 1'b0 || mismatch_count !== 16'd0 || sample_count !== 16'd5) begin failures++;
      $display("FAIL mask_unmasked: to=%b fail=%b mc=%0d sc=%0d required 0 0 0 5", to, fail, mismatch_count, sample_count); end
    do_start(5, 1'b1, 2'b11);
    drive_streams(5, 0, 1'b1, -1, to);
    checks++; if (to || done !== 1'b1 || sample_count !== 16'd3 || mismatch_count !== 16'd1) begin failures++;
      $display("FAIL stop_on_fail: to=%b done=%b sc=%0d mc=%0d required 0 1 3 1", to, done, sample_count, mismatch_count); end
  endtask

  task automatic test_backpressure();
    bit to;
    gen_vectors(8, 0);
    do_start(8, 1'b0, 2'b11);
    drive_streams(8, 6, 1'b0, -1, to);
    checks++; if (lag_gm_acc !== 4 || lag_gm_ready !== 1'b0) begin failures++;
      $display("FAIL bp_full: accepted=%0d ready=%b required 4 0", lag_gm_acc, lag_gm_ready); end
    checks++; if (to || sample_count !== 16'd8 || fail !== 1'b0) begin failures++;
      $display("FAIL bp_result: to=%b sc=%0d fail=%b required 0 8 0", to, sample_count, fail); end
  endtask

  task automatic test_reset_midrun();
    bit to;
    gen_vectors(8, 50);
    do_start(8, 1'b0, 2'b11);
    drive_streams(8, 0, 1'b0, 3, to);
    checks++; if (to || busy !== 1'b1) begin failures++;
      $display("FAIL rst_mid_reach: to=%b busy=%b required 0 1", to, busy); end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || gm_ready !== 1'b0 || fm_ready !== 1'b0 ||
                  sample_count !== 16'd0 || mismatch_count !== 16'd0 || fail !== 1'b0 ||
                  first_idx !== 16'd0 || first_lanes !== 2'b00 || first_gm !== 32'd0 || first_fm !== 32'd0) begin
      failures++;
      $display("FAIL rst_mid_clear: busy=%b done=%b sc=%0d mc=%0d idx=%0d required all 0",
               busy, done, sample_count, mismatch_count, first_idx);
    end
    gen_vectors(2, 0);
    do_start(2, 1'b0, 2'b11);
    drive_streams(2, 0, 1'b1, -1, to);
    checks++; if (to || sample_count !== 16'd2 || fail !== 1'b0) begin failures++;
      $display("FAIL rst_mid_fresh: to=%b sc=%0d fail=%b required 0 2 0", to, sample_count, fail); end
  endtask

  task automatic test_zero_and_restart();
    bit to;
    do_start(0, 1'b0, 2'b11);
    checks++; if (done !== 1'b1 || busy !== 1'b0 || sample_count !== 16'd0 || mismatch_count !== 16'd0) begin failures++;
      $display("FAIL zero_total: done=%b busy=%b sc=%0d mc=%0d required 1 0 0 0", done, busy, sample_count, mismatch_count); end
    gen_vectors(3, 0);
    do_start(3, 1'b0, 2'b11);
    do_start(1, 1'b0, 2'b11);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL start_in_run_busy: busy=%b required 1", busy); end
    drive_streams(3, 0, 1'b1, -1, to);
    checks++; if (to || sample_count !== 16'd3) begin failures++;
      $display("FAIL start_in_run_total: to=%b sc=%0d required 0 3", to, sample_count); end
  endtask

  task automatic test_random();
    bit to;
    for (int it = 0; it < 12; it++) begin
      int n;
      logic [1:0] mask;
      logic stop;
      n = 1 + $urandom_range(15);
      mask = 2'($urandom_range(3));
      stop = 1'($urandom_range(1));
      gen_vectors(n, 25);
      model(n, mask, stop);
      do_start(n, stop, mask);
      drive_streams(n, int'($urandom_range(5)), 1'b1, -1, to);
      checks++;
      if (to || int'(sample_count) !== exp_sc || int'(mismatch_count) !== exp_mc || fail !== (exp_mc != 0)) begin
        failures++;
        $display("FAIL rand%0d_counts: to=%b sc=%0d mc=%0d required sc=%0d mc=%0d", it, to, sample_count, mismatch_count, exp_sc, exp_mc);
      end
      checks++;
      if (int'(first_idx) !== exp_idx || first_lanes !== exp_lanes || first_gm !== exp_gm || first_fm !== exp_fm) begin
        failures++;
        $display("FAIL rand%0d_first: idx=%0d lanes=%b gm=%h fm=%h required %0d %b %h %h",
                 it, first_idx, first_lanes, first_gm, first_fm, exp_idx, exp_lanes, exp_gm, exp_fm);
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_identical();
    test_single_mismatch();
    test_mask_and_stop();
    test_backpressure();
    test_reset_midrun();
    test_zero_and_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
